// File: rtl/noc_arb_pkg.sv
// Shared types and helpers for the round-robin grant arbiter.
// Vectors are searched through a fixed 32-bit window, so N_INPUT may be at most 32.
package noc_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_e;

  localparam int ARB_MAX_N = 32;

  // Lowest set bit index; returns 0 for an all-zero vector (callers gate on |vec).
  function automatic int first_set_idx(input logic [ARB_MAX_N-1:0] vec);
    int idx;
    idx = 0;
    for (int i = ARB_MAX_N - 1; i >= 0; i--) begin
      if (vec[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_grant_arbiter_if.sv
// Request/grant bundle between requester ports and the grant consumer.
// The slave modport is the arbiter's view of the bundle.
interface rr_grant_arbiter_if #(
  parameter int N_INPUT = 2
);
  localparam int N_INPUT_WIDTH = (N_INPUT > 1) ? $clog2(N_INPUT) : 1;

  logic [N_INPUT-1:0]       req_i;
  logic                     grant_ready_i;
  logic                     grant_valid_o;
  logic [N_INPUT-1:0]       grant_o;
  logic [N_INPUT_WIDTH-1:0] grant_idx_o;
  logic [N_INPUT_WIDTH-1:0] ptr_o;

  modport master (
    output req_i, grant_ready_i,
    input  grant_valid_o, grant_o, grant_idx_o, ptr_o
  );

  modport slave (
    input  req_i, grant_ready_i,
    output grant_valid_o, grant_o, grant_idx_o, ptr_o
  );
endinterface

// File: rtl/left_circular_rotate.sv
// Rotates the request vector so that bit k of the result is request (amt + k) mod N_INPUT.
// The priority pointer therefore lands at bit 0 and the encoder simply looks for the lowest set bit.
module left_circular_rotate #(
  parameter int N_INPUT       = 2,
  parameter int N_INPUT_WIDTH = 1
) (
  input  logic [N_INPUT-1:0]       vec,
  input  logic [N_INPUT_WIDTH-1:0] amt,
  output logic [N_INPUT-1:0]       rot
);
  localparam logic [N_INPUT_WIDTH:0] N_EXT = (N_INPUT_WIDTH + 1)'(N_INPUT);

  logic [N_INPUT_WIDTH:0] pos;

  always_comb begin
    rot = '0;
    pos = '0;
    for (int k = 0; k < N_INPUT; k++) begin
      pos = {1'b0, amt} + (N_INPUT_WIDTH + 1)'(k);
      if (pos >= N_EXT) pos = pos - N_EXT;
      rot[k] = vec[pos[N_INPUT_WIDTH-1:0]];
    end
  end

endmodule

// File: rtl/rr_grant_arbiter.sv
// Registered round-robin arbiter: picks the first requester at or after the pointer,
// holds the grant until accepted, and re-arbitrates on the accepting edge for back-to-back grants.
module rr_grant_arbiter
  import noc_arb_pkg::*;
#(
  parameter int N_INPUT = 2
) (
  input  logic              clk,
  input  logic              rstn,
  rr_grant_arbiter_if.slave bus
);
  localparam int                     W     = (N_INPUT > 1) ? $clog2(N_INPUT) : 1;
  localparam logic [W:0]             N_EXT = (W + 1)'(N_INPUT);
  localparam logic [W-1:0]           LAST  = W'(N_INPUT - 1);

  arb_state_e         state, state_nxt;
  logic [W-1:0]       ptr, ptr_nxt;
  logic [W-1:0]       idx_q;
  logic [N_INPUT-1:0] grant_q;
  logic               load;
  logic               any_req;
  logic [N_INPUT-1:0] rot;
  logic [W-1:0]       first;
  logic [W:0]         sum;
  logic [W-1:0]       win_idx;

  assign any_req = |bus.req_i;

  // The rotation uses the post-accept pointer so a back-to-back winner already excludes
  // the requester just served (unless it is the only one asking).
  left_circular_rotate #(
    .N_INPUT       (N_INPUT),
    .N_INPUT_WIDTH (W)
  ) u_rotate (
    .vec (bus.req_i),
    .amt (ptr_nxt),
    .rot (rot)
  );

  assign first   = W'(first_set_idx(ARB_MAX_N'(rot)));
  assign sum     = {1'b0, ptr_nxt} + {1'b0, first};
  assign win_idx = (sum >= N_EXT) ? W'(sum - N_EXT) : sum[W-1:0];

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    load      = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (any_req) begin
          load      = 1'b1;
          state_nxt = ARB_GRANT;
        end
      end
      ARB_GRANT: begin
        if (bus.grant_ready_i) begin
          ptr_nxt = (idx_q == LAST) ? '0 : idx_q + 1'b1;
          if (any_req) load = 1'b1;
          else         state_nxt = ARB_IDLE;
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= ARB_IDLE;
      ptr     <= '0;
      idx_q   <= '0;
      grant_q <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      if (load) begin
        idx_q   <= win_idx;
        grant_q <= N_INPUT'(1) << win_idx;
      end else if (state_nxt == ARB_IDLE) begin
        grant_q <= '0;
      end
    end
  end

  assign bus.grant_valid_o = (state == ARB_GRANT);
  assign bus.grant_o       = grant_q;
  assign bus.grant_idx_o   = idx_q;
  assign bus.ptr_o         = ptr;

  a_grant_onehot0: assert property (@(posedge clk) disable iff (!rstn) $onehot0(grant_q));

  a_grant_matches_idx: assert property (@(posedge clk) disable iff (!rstn)
    (state == ARB_GRANT) |-> (grant_q == (N_INPUT'(1) << idx_q)));

  a_grant_stable: assert property (@(posedge clk) disable iff (!rstn)
    ((state == ARB_GRANT) && !bus.grant_ready_i) |=>
      ((state == ARB_GRANT) && $stable(grant_q) && $stable(idx_q)));

  a_ptr_range: assert property (@(posedge clk) disable iff (!rstn) (ptr <= LAST));

endmodule
